// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
// Bundles the front-end and pipeline-side signals of cpu_run_ctrl.
//   master : control/debug front end (drives requests, observes run status)
//   slave  : cpu_run_ctrl itself
// Request side : init_calib_complete, cpu_start, start_adr, quit_cmd,
//                stall_src, stall_mask (+ step_mode, step_req when
//                CPU_RUN_CTRL_STEP_EN is defined)
// Status side  : cpu_run_state, cpu_stopping, pc_start, start_adr_lat,
//                pc_valid_id, stall, stall_dly, stall_1shot, rst_pipe
interface cpu_run_ctrl_if #(
    parameter int NSTAGE = 4,
    parameter int NSTALL = 2
) ();
    logic              init_calib_complete;
    logic              cpu_start;
    logic [31:2]       start_adr;
    logic              quit_cmd;
    logic [NSTALL-1:0] stall_src;
    logic [NSTALL-1:0] stall_mask;
`ifdef CPU_RUN_CTRL_STEP_EN
    logic              step_mode;
    logic              step_req;
`endif
    logic              cpu_run_state;
    logic              cpu_stopping;
    logic              pc_start;
    logic [31:2]       start_adr_lat;
    logic              pc_valid_id;
    logic              stall;
    logic [NSTAGE-1:0] stall_dly;
    logic [NSTAGE-1:0] stall_1shot;
    logic [NSTAGE-1:0] rst_pipe;

    modport master (
        output init_calib_complete, cpu_start, start_adr, quit_cmd,
               stall_src, stall_mask,
`ifdef CPU_RUN_CTRL_STEP_EN
               step_mode, step_req,
`endif
        input  cpu_run_state, cpu_stopping, pc_start, start_adr_lat,
               pc_valid_id, stall, stall_dly, stall_1shot, rst_pipe
    );

    modport slave (
        input  init_calib_complete, cpu_start, start_adr, quit_cmd,
               stall_src, stall_mask,
`ifdef CPU_RUN_CTRL_STEP_EN
               step_mode, step_req,
`endif
        output cpu_run_state, cpu_stopping, pc_start, start_adr_lat,
               pc_valid_id, stall, stall_dly, stall_1shot, rst_pipe
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run control between the debug front end and the RV32I pipeline.
// Sequences IDLE -> (PEND) -> RUN -> DRAIN -> IDLE, merges maskable stall
// sources into one pipeline stall and fans out per-stage delayed stall,
// stall rising-edge and flush pulses.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : cpu_run_ctrl_if.slave (see interface file for signal list)
// Optional feature macro: CPU_RUN_CTRL_STEP_EN (single-step support via
// bus.step_mode / bus.step_req).
module cpu_run_ctrl #(
    parameter int NSTAGE    = 4,
    parameter int NSTALL    = 2,
    parameter int DRAIN_CYC = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_run_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [31:2]       start_adr_lat_r;
    logic              pc_valid_id_r;
    logic [NSTAGE-1:0] stall_dly_r;
    logic [NSTAGE-1:0] rst_pipe_r;
    logic [NSTAGE-1:0] stall_1shot_s;
    logic              run_s;
    logic              src_stall_s;
    logic              stall_s;
    logic              first_run_s;

    assign run_s       = (state_r == ST_RUN);
    assign src_stall_s = |(bus.stall_src & bus.stall_mask);
    assign first_run_s = (state_nxt_s == ST_RUN) && (state_r != ST_RUN);

`ifdef CPU_RUN_CTRL_STEP_EN
    // A step request stays armed until the masked sources let it through.
    logic step_arm_r;

    // Step arm register: set by step_req in stepped RUN, consumed on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_arm_r <= 1'b0;
        end else if (run_s && bus.step_mode) begin
            step_arm_r <= bus.step_req | (step_arm_r & src_stall_s);
        end else begin
            step_arm_r <= 1'b0;
        end
    end

    assign stall_s = ~run_s | src_stall_s | (bus.step_mode & ~step_arm_r);
`else
    assign stall_s = ~run_s | src_stall_s;
`endif

    // Next-state and drain-counter logic; ~calib > quit_cmd > cpu_start.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.quit_cmd) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.cpu_start) begin
                    if (bus.init_calib_complete) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PEND;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (bus.quit_cmd) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.init_calib_complete) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            ST_RUN: begin
                if (!bus.init_calib_complete) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.quit_cmd) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = CNT_W'(DRAIN_CYC);
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!bus.init_calib_complete) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (!src_stall_s) begin
                    // A zero count is treated like 1 so DRAIN can never lock up.
                    if (cnt_r <= CNT_W'(1)) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_r - CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, latched PC and per-stage shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            start_adr_lat_r <= 30'd0;
            pc_valid_id_r   <= 1'b0;
            stall_dly_r     <= {NSTAGE{1'b1}};
            rst_pipe_r      <= {NSTAGE{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            pc_valid_id_r <= run_s;
            if (bus.cpu_start) begin
                start_adr_lat_r <= bus.start_adr;
            end else begin
                start_adr_lat_r <= start_adr_lat_r;
            end
            stall_dly_r[0] <= stall_s;
            rst_pipe_r[0]  <= first_run_s;
            for (int k = 1; k < NSTAGE; k++) begin
                stall_dly_r[k] <= stall_dly_r[k-1];
                rst_pipe_r[k]  <= rst_pipe_r[k-1];
            end
        end
    end

    // Rising edge of the stall as seen by each stage.
    always_comb begin
        stall_1shot_s    = {NSTAGE{1'b0}};
        stall_1shot_s[0] = stall_s & ~stall_dly_r[0];
        for (int k = 1; k < NSTAGE; k++) begin
            stall_1shot_s[k] = stall_dly_r[k-1] & ~stall_dly_r[k];
        end
    end

    assign bus.cpu_run_state = run_s;
    assign bus.cpu_stopping  = (state_r == ST_DRAIN);
    assign bus.pc_start      = rst_pipe_r[0];
    assign bus.start_adr_lat = start_adr_lat_r;
    assign bus.pc_valid_id   = pc_valid_id_r;
    assign bus.stall         = stall_s;
    assign bus.stall_dly     = stall_dly_r;
    assign bus.stall_1shot   = stall_1shot_s;
    assign bus.rst_pipe      = rst_pipe_r;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
// Directed stimulus pushes (cycle, signal, value) expectations into a queue;
// a monitor on the falling edge compares every expectation due that cycle.
module tb_cpu_run_ctrl;
    localparam int NSTAGE    = 4;
    localparam int NSTALL    = 2;
    localparam int DRAIN_CYC = 7;

    localparam int S_RUN   = 0;
    localparam int S_STOP  = 1;
    localparam int S_PCS   = 2;
    localparam int S_LAT   = 3;
    localparam int S_PCV   = 4;
    localparam int S_STALL = 5;
    localparam int S_DLY   = 6;
    localparam int S_1SH   = 7;
    localparam int S_RP    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.NSTAGE(NSTAGE), .NSTALL(NSTALL)) bus ();

    cpu_run_ctrl #(.NSTAGE(NSTAGE), .NSTALL(NSTALL), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_RUN:   return 32'(bus.cpu_run_state);
            S_STOP:  return 32'(bus.cpu_stopping);
            S_PCS:   return 32'(bus.pc_start);
            S_LAT:   return 32'(bus.start_adr_lat);
            S_PCV:   return 32'(bus.pc_valid_id);
            S_STALL: return 32'(bus.stall);
            S_DLY:   return 32'(bus.stall_dly);
            S_1SH:   return 32'(bus.stall_1shot);
            S_RP:    return 32'(bus.rst_pipe);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            S_RUN:   return "cpu_run_state";
            S_STOP:  return "cpu_stopping";
            S_PCS:   return "pc_start";
            S_LAT:   return "start_adr_lat";
            S_PCV:   return "pc_valid_id";
            S_STALL: return "stall";
            S_DLY:   return "stall_dly";
            S_1SH:   return "stall_1shot";
            S_RP:    return "rst_pipe";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                n_chk++;
                if (exp_q[i].cyc == cyc && sample(exp_q[i].sig) === exp_q[i].val) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h",
                             sig_name(exp_q[i].sig), cyc, exp_q[i].cyc,
                             sample(exp_q[i].sig), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    task automatic check_now(input int sig, input logic [31:0] v);
        n_chk++;
        if (sample(sig) === v) begin
            n_pass++;
        end else begin
            $display("FAIL reset %s t=%0t got=%h exp=%h",
                     sig_name(sig), $time, sample(sig), v);
        end
    endtask

    task automatic check_reset_now();
        check_now(S_RUN,   32'h0);
        check_now(S_STOP,  32'h0);
        check_now(S_PCS,   32'h0);
        check_now(S_LAT,   32'h0);
        check_now(S_PCV,   32'h0);
        check_now(S_STALL, 32'h1);
        check_now(S_DLY,   32'hF);
        check_now(S_1SH,   32'h0);
        check_now(S_RP,    32'h0);
    endtask

    task automatic expect_at(input int dc, input int sig, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + dc;
        e.sig = sig;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) step_cyc();
    endtask

    task automatic expect_reset_vals();
        expect_at(0, S_RUN,   32'h0);
        expect_at(0, S_STOP,  32'h0);
        expect_at(0, S_PCS,   32'h0);
        expect_at(0, S_LAT,   32'h0);
        expect_at(0, S_PCV,   32'h0);
        expect_at(0, S_STALL, 32'h1);
        expect_at(0, S_DLY,   32'hF);
        expect_at(0, S_1SH,   32'h0);
        expect_at(0, S_RP,    32'h0);
    endtask

    // Pulse cpu_start from IDLE with calibration done; RUN expected next cycle.
    task automatic do_start(input logic [31:2] adr);
        bus.start_adr = adr;
        bus.cpu_start = 1'b1;
        expect_at(1, S_RUN, 32'h1);
        step_cyc();
        bus.cpu_start = 1'b0;
    endtask

    initial begin
        bus.init_calib_complete = 1'b1;
        bus.cpu_start  = 1'b0;
        bus.start_adr  = 30'd0;
        bus.quit_cmd   = 1'b0;
        bus.stall_src  = 2'b00;
        bus.stall_mask = 2'b11;
`ifdef CPU_RUN_CTRL_STEP_EN
        bus.step_mode  = 1'b0;
        bus.step_req   = 1'b0;
`endif
        wait_cyc(2);
        check_reset_now();
        expect_reset_vals();
        step_cyc();
        rst_n = 1'b1;
        step_cyc();

        // Start from IDLE, calibration done.
        bus.start_adr = 30'h100;
        bus.cpu_start = 1'b1;
        expect_at(0, S_RUN, 32'h0);
        expect_at(0, S_PCS, 32'h0);
        expect_at(1, S_RUN, 32'h1);
        expect_at(1, S_PCS, 32'h1);
        expect_at(1, S_RP, 32'h1);
        expect_at(1, S_LAT, 32'h100);
        expect_at(1, S_PCV, 32'h0);
        expect_at(1, S_STALL, 32'h0);
        expect_at(1, S_DLY, 32'hF);
        expect_at(1, S_1SH, 32'h0);
        expect_at(2, S_PCS, 32'h0);
        expect_at(2, S_PCV, 32'h1);
        expect_at(2, S_RP, 32'h2);
        expect_at(2, S_DLY, 32'hE);
        expect_at(3, S_RP, 32'h4);
        expect_at(4, S_RP, 32'h8);
        expect_at(5, S_RP, 32'h0);
        expect_at(5, S_DLY, 32'h0);
        step_cyc();
        bus.cpu_start = 1'b0;
        wait_cyc(6);

        // Two-cycle stall from source 1 while running.
        bus.stall_src = 2'b10;
        expect_at(0, S_STALL, 32'h1);
        expect_at(0, S_1SH, 32'h1);
        expect_at(1, S_STALL, 32'h1);
        expect_at(1, S_1SH, 32'h2);
        expect_at(2, S_STALL, 32'h0);
        expect_at(2, S_1SH, 32'h4);
        expect_at(2, S_DLY, 32'h3);
        expect_at(3, S_1SH, 32'h8);
        expect_at(3, S_DLY, 32'h6);
        expect_at(4, S_DLY, 32'hC);
        expect_at(5, S_DLY, 32'h8);
        expect_at(6, S_DLY, 32'h0);
        wait_cyc(2);
        bus.stall_src = 2'b00;
        wait_cyc(6);

        // Quit with no stalls: DRAIN lasts DRAIN_CYC cycles.
        bus.quit_cmd = 1'b1;
        expect_at(0, S_RUN, 32'h1);
        expect_at(0, S_STOP, 32'h0);
        expect_at(1, S_RUN, 32'h0);
        expect_at(1, S_STOP, 32'h1);
        expect_at(1, S_STALL, 32'h1);
        expect_at(7, S_STOP, 32'h1);
        expect_at(8, S_STOP, 32'h0);
        step_cyc();
        bus.quit_cmd = 1'b0;
        wait_cyc(9);

        // Quit with source 0 stalling for three DRAIN cycles.
        do_start(30'h100);
        wait_cyc(3);
        bus.quit_cmd = 1'b1;
        expect_at(1, S_STOP, 32'h1);
        expect_at(4, S_STOP, 32'h1);
        expect_at(10, S_STOP, 32'h1);
        expect_at(11, S_STOP, 32'h0);
        step_cyc();
        bus.quit_cmd = 1'b0;
        step_cyc();
        bus.stall_src = 2'b01;
        wait_cyc(3);
        bus.stall_src = 2'b00;
        wait_cyc(8);

        // Same, but source 0 masked off: stall ignored.
        do_start(30'h100);
        wait_cyc(3);
        bus.stall_mask = 2'b10;
        bus.quit_cmd = 1'b1;
        expect_at(7, S_STOP, 32'h1);
        expect_at(8, S_STOP, 32'h0);
        step_cyc();
        bus.quit_cmd = 1'b0;
        step_cyc();
        bus.stall_src = 2'b01;
        wait_cyc(3);
        bus.stall_src = 2'b00;
        wait_cyc(6);
        bus.stall_mask = 2'b11;

        // Start while calibration pending, then calibration completes.
        bus.init_calib_complete = 1'b0;
        bus.start_adr = 30'h2A5;
        bus.cpu_start = 1'b1;
        expect_at(1, S_RUN, 32'h0);
        expect_at(1, S_LAT, 32'h2A5);
        expect_at(2, S_RUN, 32'h0);
        step_cyc();
        bus.cpu_start = 1'b0;
        step_cyc();
        bus.init_calib_complete = 1'b1;
        expect_at(0, S_RUN, 32'h0);
        expect_at(1, S_RUN, 32'h1);
        expect_at(1, S_PCS, 32'h1);
        wait_cyc(4);

        // Calibration lost in RUN: straight back to IDLE.
        bus.init_calib_complete = 1'b0;
        expect_at(0, S_RUN, 32'h1);
        expect_at(1, S_RUN, 32'h0);
        expect_at(1, S_STOP, 32'h0);
        step_cyc();

        // Start into PEND, then quit: no run, no pc_start afterwards.
        bus.cpu_start = 1'b1;
        step_cyc();
        bus.cpu_start = 1'b0;
        bus.quit_cmd = 1'b1;
        expect_at(1, S_RUN, 32'h0);
        step_cyc();
        bus.quit_cmd = 1'b0;
        bus.init_calib_complete = 1'b1;
        expect_at(1, S_RUN, 32'h0);
        expect_at(1, S_PCS, 32'h0);
        expect_at(2, S_RUN, 32'h0);
        wait_cyc(3);

        // Calibration lost mid-DRAIN; cpu_start in DRAIN only latches the PC.
        do_start(30'h100);
        wait_cyc(3);
        bus.quit_cmd = 1'b1;
        step_cyc();
        bus.quit_cmd = 1'b0;
        bus.start_adr = 30'h1234;
        bus.cpu_start = 1'b1;
        expect_at(0, S_STOP, 32'h1);
        expect_at(1, S_LAT, 32'h1234);
        expect_at(1, S_RUN, 32'h0);
        expect_at(1, S_STOP, 32'h1);
        step_cyc();
        bus.cpu_start = 1'b0;
        step_cyc();
        bus.init_calib_complete = 1'b0;
        expect_at(0, S_STOP, 32'h1);
        expect_at(1, S_STOP, 32'h0);
        expect_at(1, S_RUN, 32'h0);
        step_cyc();
        bus.init_calib_complete = 1'b1;
        wait_cyc(2);

        // Asynchronous reset mid-RUN.
        do_start(30'h100);
        wait_cyc(3);
        rst_n = 1'b0;
        #1;
        check_reset_now();
        expect_reset_vals();
        step_cyc();
        rst_n = 1'b1;
        wait_cyc(2);

`ifdef CPU_RUN_CTRL_STEP_EN
        // Single-step: stall released for one cycle per step_req.
        do_start(30'h100);
        wait_cyc(5);
        bus.step_mode = 1'b1;
        expect_at(0, S_STALL, 32'h1);
        expect_at(1, S_STALL, 32'h1);
        wait_cyc(2);
        bus.step_req = 1'b1;
        expect_at(0, S_STALL, 32'h1);
        expect_at(1, S_STALL, 32'h0);
        expect_at(2, S_STALL, 32'h1);
        step_cyc();
        bus.step_req = 1'b0;
        wait_cyc(3);
        // Step requested while source 0 stalls: held until it clears.
        bus.stall_src = 2'b01;
        bus.step_req = 1'b1;
        expect_at(1, S_STALL, 32'h1);
        expect_at(2, S_STALL, 32'h1);
        expect_at(3, S_STALL, 32'h0);
        expect_at(4, S_STALL, 32'h1);
        step_cyc();
        bus.step_req = 1'b0;
        wait_cyc(2);
        bus.stall_src = 2'b00;
        wait_cyc(3);
        bus.step_mode = 1'b0;
        wait_cyc(2);
`endif

        wait_cyc(3);
        if (exp_q.size() != 0) begin
            $display("FAIL %0d expectation(s) never checked", exp_q.size());
        end else begin
            $display("all expectations consumed");
        end
        if (n_pass != n_chk) begin
            $display("FAIL %0d/%0d checks passed", n_pass, n_chk);
        end else begin
            $display("%0d/%0d checks passed", n_pass, n_chk);
        end
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised CPU run-control block that sits between the control/debug front end and the RV32I pipeline. It sequences start (deferred until memory calibration completes), run, and drain-on-quit through an explicit state machine. It merges N maskable stall sources into one pipeline stall and fans out per-stage delayed stall, stall-edge and pipeline-flush signals for an NSTAGE-deep pipeline.

## Interface
- NSTAGE, 4, pipeline stages after IF (ID, EX, MA, WB…); width of per-stage vectors
- NSTALL, 2, number of stall sources (bit 0 = D$, bit 1 = I$, …)
- DRAIN_CYC, 7, drain cycles after quit_cmd (1..255)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- init_calib_complete  in  1  memory calibration done
- cpu_start  in  1  start request pulse
- start_adr  in  [31:2]  start PC
- quit_cmd  in  1  stop request pulse
- stall_src  in  NSTALL  raw stall requests
- stall_mask  in  NSTALL  1 = source enabled (quasi-static)
- cpu_run_state  out  1  high only in RUN
- cpu_stopping  out  1  high only in DRAIN
- pc_start  out  1  one-cycle pulse, first RUN cycle
- start_adr_lat  out  [31:2]  latched start PC
- pc_valid_id  out  1  cpu_run_state delayed 1 cycle
- stall  out  1  merged pipeline stall
- stall_dly  out  NSTAGE  bit k = stall delayed k+1 cycles
- stall_1shot  out  NSTAGE  stall rising edge per stage
- rst_pipe  out  NSTAGE  flush pulse per stage

## Operation
- States: IDLE, PEND, RUN, DRAIN; reset → IDLE.
- start_adr_lat loads start_adr on any cpu_start cycle, any state, quit_cmd not blocking.
- IDLE: cpu_start & calib → RUN; cpu_start & ~calib → PEND.
- PEND: quit_cmd → IDLE; calib → RUN.
- RUN: ~calib → IDLE; quit_cmd → DRAIN, counter loaded with DRAIN_CYC.
- DRAIN: ~calib → IDLE, counter cleared; counter decrements in cycles where (stall_src & stall_mask)==0; decrement from 1 → IDLE. cpu_start ignored (start_adr still latched).
- Priority in any state: ~calib > quit_cmd > cpu_start. quit_cmd and cpu_start in same IDLE cycle → stay IDLE.
- Counter width = $clog2(DRAIN_CYC+1).
- stall = ~cpu_run_state | |(stall_src & stall_mask) (combinational).
- stall_1shot[0] = stall & ~stall_dly[0]; stall_1shot[k] = stall_dly[k-1] & ~stall_dly[k].
- rst_pipe[0] high for exactly the first RUN cycle; rst_pipe[k] = rst_pipe[k-1] delayed 1.

## Timing
- Reset values: state IDLE, cpu_run_state 0, cpu_stopping 0, pc_start 0, pc_valid_id 0, start_adr_lat 0, stall_dly all 1, rst_pipe all 0, counter 0; stall=1, stall_1shot=0.
- cpu_start at cycle T (calib=1, IDLE) → cpu_run_state, pc_start, rst_pipe[0] high at T+1; pc_valid_id at T+2; rst_pipe[k] at T+1+k.
- PEND → RUN one cycle after calib seen high.
- quit_cmd at T in RUN → cpu_run_state 0 and cpu_stopping 1 at T+1; with no stalls cpu_stopping falls at T+1+DRAIN_CYC.
- Reset mid-DRAIN or mid-RUN: immediate return to reset values.

## Configuration
- CPU_RUN_CTRL_STEP_EN defined: adds inputs step_mode (1) and step_req (1-cycle pulse). In RUN with step_mode=1, stall held 1 except the cycle after a step_req pulse, where stall = masked stall sources only; step_req while masked sources stall is held pending until they clear. step_req outside RUN discarded.
- Undefined: ports absent; behaviour identical to step_mode=0.

## Test plan
- Reset, calib=1, cpu_start at T with start_adr=0x100 → start_adr_lat=0x100, pc_start/rst_pipe[0] at T+1, rst_pipe[3] at T+4, pc_valid_id at T+2.
- calib=0, cpu_start → PEND; calib rises at T → cpu_run_state at T+1; repeat with quit_cmd in PEND → IDLE, no pc_start.
- RUN, quit_cmd at T, stall_src=0 → cpu_stopping T+1..T+7; with stall_src[0]=1 for 3 DRAIN cycles → ends at T+10; stall_mask[0]=0 → ends at T+7.
- RUN, stall_src[1] pulsed 2 cycles at T → stall T..T+1, stall_1shot[0] at T, stall_1shot[2] at T+2, stall_dly[3] high T+4..T+5.
- calib drops mid-DRAIN → IDLE next cycle, cpu_stopping 0; async reset mid-RUN → all reset values immediately.
- STEP_EN: step_mode=1, step_req at T → stall low only at T+1; step_req during stall_src[0]=1 → single low cycle after source clears.
